// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: opcode constants, default field
// widths and the hazard controller state encoding.
package cpu_pkg;

  localparam int OP_W_DEF = 4;
  localparam int RA_W_DEF = 4;

  localparam logic [OP_W_DEF-1:0] OP_ALU = 4'b0000;
  localparam logic [OP_W_DEF-1:0] OP_LW  = 4'b0001;
  localparam logic [OP_W_DEF-1:0] OP_SW  = 4'b0010;
  localparam logic [OP_W_DEF-1:0] OP_BEQ = 4'b0011;
  localparam logic [OP_W_DEF-1:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LU_STALL   = 2'd1,
    HZ_HALT_DRAIN = 2'd2,
    HZ_HALTED     = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage pipeline logic (master) and the hazard
// controller (slave), including the controller's debug view of its FSM.
interface hazard_ctrl_if
  import cpu_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
);

  // Enables are level signals sampled on the rising clock edge: a stage
  // register updates only in a cycle where its write enable is 1; flush and
  // bubble override the loaded contents with a NOP in that same cycle.
  logic [OP_W-1:0]  id_opcode;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [RA_W-1:0]  ex_rt;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  hz_state_e        dbg_state;
  logic [2:0]       dbg_cnt;

  modport master (
    output id_opcode, id_rs, id_rt, id_rs_used, id_rt_used,
    output ex_rt, ex_mem_read, branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  halted, stall_cnt, dbg_state, dbg_cnt
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_rs_used, id_rt_used,
    input  ex_rt, ex_mem_read, branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output halted, stall_cnt, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stalls, taken-branch flush,
// data-memory freeze, sticky halt with drain, and a stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int              OP_W     = OP_W_DEF,
  parameter int              RA_W     = RA_W_DEF,
  parameter logic [OP_W-1:0] HLT_OP   = OP_W'(OP_HLT),
  parameter int              LOAD_LAT = 1,
  parameter int              DRAIN    = 3,
  parameter int              ZERO_REG = 1,
  parameter int              CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);
  localparam logic [2:0] DRAIN_M1 = 3'(DRAIN - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       halted_q, halted_d;

  logic rs_match, rt_match, zero_block, lu_hit;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic bubble_inc;

  always_comb begin
    rs_match   = hz.id_rs_used && (hz.id_rs == hz.ex_rt);
    rt_match   = hz.id_rt_used && (hz.id_rt == hz.ex_rt);
    zero_block = (ZERO_REG != 0) && (hz.ex_rt == {RA_W{1'b0}});
    lu_hit     = hz.ex_mem_read && (rs_match || rt_match) && !zero_block;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    if (rst) begin
      id_ex_bubble = 1'b1;
    end else if (state_q == HZ_HALTED) begin
      // Terminal until reset; the freeze and branch inputs no longer matter.
      id_ex_bubble = 1'b1;
    end else if (hz.mem_busy) begin
      // Whole pipe frozen: all enables low, state and counters hold.
      state_d = state_q;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (hz.branch_taken) begin
            // The instruction in ID is squashed, so HLT/load-use there is moot.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hz.id_opcode == HLT_OP) begin
            id_ex_bubble = 1'b1;
            if (DRAIN == 1) begin
              state_d = HZ_HALTED;
            end else begin
              state_d = HZ_HALT_DRAIN;
              cnt_d   = DRAIN_M1;
            end
          end else if (lu_hit) begin
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = HZ_LU_STALL;
              cnt_d   = LAT_M1;
            end
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        HZ_LU_STALL: begin
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = HZ_RUN;
          end
        end
        HZ_HALT_DRAIN: begin
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = HZ_HALTED;
          end
        end
        default: begin
          id_ex_bubble = 1'b1;
        end
      endcase
    end

    halted_d = (state_d == HZ_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HZ_RUN;
      cnt_q    <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // Flush bubbles come from a squashed branch shadow, not a stall.
  assign bubble_inc = id_ex_bubble && !if_id_flush && !rst;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (hz.stall_cnt)
  );

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.halted       = halted_q;
  assign hz.dbg_state    = state_q;
  assign hz.dbg_cnt      = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three differently parameterised instances share one
// input stream and are checked against a bubble-budget model of the pipeline.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam logic [3:0] HLT = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] opc = '0, rs = '0, rt = '0, ex_rt = '0;
  logic       rs_used = 0, rt_used = 0, ex_mem_read = 0, branch = 0, busy = 0;

  hazard_ctrl_if #(.OP_W(4), .RA_W(4), .CNT_W(16)) if_a ();
  hazard_ctrl_if #(.OP_W(4), .RA_W(4), .CNT_W(16)) if_b ();
  hazard_ctrl_if #(.OP_W(4), .RA_W(4), .CNT_W(4))  if_c ();

  assign {if_a.id_opcode, if_a.id_rs, if_a.id_rt, if_a.id_rs_used, if_a.id_rt_used} = {opc, rs, rt, rs_used, rt_used};
  assign {if_a.ex_rt, if_a.ex_mem_read, if_a.branch_taken, if_a.mem_busy} = {ex_rt, ex_mem_read, branch, busy};
  assign {if_b.id_opcode, if_b.id_rs, if_b.id_rt, if_b.id_rs_used, if_b.id_rt_used} = {opc, rs, rt, rs_used, rt_used};
  assign {if_b.ex_rt, if_b.ex_mem_read, if_b.branch_taken, if_b.mem_busy} = {ex_rt, ex_mem_read, branch, busy};
  assign {if_c.id_opcode, if_c.id_rs, if_c.id_rt, if_c.id_rs_used, if_c.id_rt_used} = {opc, rs, rt, rs_used, rt_used};
  assign {if_c.ex_rt, if_c.ex_mem_read, if_c.branch_taken, if_c.mem_busy} = {ex_rt, ex_mem_read, branch, busy};

  hazard_ctrl #(.HLT_OP(HLT), .LOAD_LAT(2), .DRAIN(3), .ZERO_REG(1), .CNT_W(16))
    u_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  hazard_ctrl #(.HLT_OP(HLT), .LOAD_LAT(3), .DRAIN(1), .ZERO_REG(0), .CNT_W(16))
    u_b (.clk(clk), .rst(rst), .hz(if_b.slave));
  hazard_ctrl #(.HLT_OP(HLT), .LOAD_LAT(1), .DRAIN(2), .ZERO_REG(1), .CNT_W(4))
    u_c (.clk(clk), .rst(rst), .hz(if_c.slave));

  // Reference model: per instance, bubbles still owed to a load, drain cycles
  // still owed to a halt, the sticky halted flag and the stall total.
  int    lat [3] = '{2, 3, 1};
  int    drn [3] = '{3, 1, 2};
  bit    zr  [3] = '{1'b1, 1'b0, 1'b1};
  int    cmax[3] = '{65535, 65535, 15};
  string nm  [3] = '{"A", "B", "C"};
  int    stall_left[3], drain_left[3], cnt_m[3];
  bit    halted_m[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      stall_left[k] = 0;
      drain_left[k] = 0;
      halted_m[k]   = 1'b0;
      cnt_m[k]      = 0;
    end
  endtask

  function automatic bit hit_m(int k);
    bit reads_dest;
    reads_dest = (rs_used && rs == ex_rt) || (rt_used && rt == ex_rt);
    return ex_mem_read && reads_dest && !(zr[k] && ex_rt == 4'd0);
  endfunction

  task automatic model_eval(input int k, output bit pc, output bit ifid, output bit fl, output bit bub);
    pc = 0; ifid = 0; fl = 0; bub = 0;
    if (rst)                                      bub = 1;
    else if (halted_m[k])                         bub = 1;
    else if (busy)                                bub = 0;
    else if (stall_left[k] > 0 || drain_left[k] > 0) bub = 1;
    else if (branch)                              begin fl = 1; bub = 1; pc = 1; ifid = 1; end
    else if (opc == HLT || hit_m(k))              bub = 1;
    else                                          begin pc = 1; ifid = 1; end
  endtask

  task automatic model_step(input int k);
    bit pc, ifid, fl, bub;
    if (rst) begin
      stall_left[k] = 0; drain_left[k] = 0; halted_m[k] = 0; cnt_m[k] = 0;
      return;
    end
    model_eval(k, pc, ifid, fl, bub);
    if (bub && !fl && cnt_m[k] < cmax[k]) cnt_m[k]++;
    if (halted_m[k] || busy) return;
    if (stall_left[k] > 0) stall_left[k]--;
    else if (drain_left[k] > 0) begin
      drain_left[k]--;
      if (drain_left[k] == 0) halted_m[k] = 1;
    end
    else if (branch) return;
    else if (opc == HLT) begin
      if (drn[k] == 1) halted_m[k] = 1;
      else drain_left[k] = drn[k] - 1;
    end
    else if (hit_m(k)) stall_left[k] = lat[k] - 1;
  endtask

  task automatic get_obs(input int k, output logic pc, output logic ifid, output logic fl,
                         output logic bub, output logic hl, output logic [15:0] sc);
    case (k)
      0: begin pc = if_a.pc_write; ifid = if_a.if_id_write; fl = if_a.if_id_flush;
               bub = if_a.id_ex_bubble; hl = if_a.halted; sc = if_a.stall_cnt; end
      1: begin pc = if_b.pc_write; ifid = if_b.if_id_write; fl = if_b.if_id_flush;
               bub = if_b.id_ex_bubble; hl = if_b.halted; sc = if_b.stall_cnt; end
      default: begin pc = if_c.pc_write; ifid = if_c.if_id_write; fl = if_c.if_id_flush;
               bub = if_c.id_ex_bubble; hl = if_c.halted; sc = 16'(if_c.stall_cnt); end
    endcase
  endtask

  // Inputs are already applied; check outputs mid-cycle, then advance the
  // model on the clock edge and settle just past it.
  task automatic run_cycle();
    logic pc, ifid, fl, bub, hl;
    logic [15:0] sc;
    bit e_pc, e_ifid, e_fl, e_bub;
    if (rst) reset_model();
    #1;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, e_pc, e_ifid, e_fl, e_bub);
      get_obs(k, pc, ifid, fl, bub, hl, sc);
      chk({nm[k], ".pc_write"}, 32'(pc), 32'(e_pc));
      chk({nm[k], ".if_id_flush"}, 32'(fl), 32'(e_fl));
      chk({nm[k], ".id_ex_bubble"}, 32'(bub), 32'(e_bub));
      if (!e_fl) chk({nm[k], ".if_id_write"}, 32'(ifid), 32'(e_ifid));
      chk({nm[k], ".halted"}, 32'(hl), 32'(halted_m[k]));
      chk({nm[k], ".stall_cnt"}, 32'(sc), 32'(cnt_m[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic cyc(input logic r, input logic [3:0] op, input logic [3:0] s, input logic [3:0] t,
                     input logic su, input logic tu, input logic [3:0] er, input logic mr,
                     input logic br, input logic bz);
    @(negedge clk);
    rst = r; opc = op; rs = s; rt = t; rs_used = su; rt_used = tu;
    ex_rt = er; ex_mem_read = mr; branch = br; busy = bz;
    run_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, OP_ALU, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0);
  endtask

  initial begin
    reset_model();
    cyc(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.state", 32'(if_a.dbg_state), 32'(HZ_RUN));
    chk("rst.cnt", 32'(if_a.dbg_cnt), 32'd0);
    idle(2);

    // Load to r5 consumed by rs in ID.
    cyc(0, OP_ALU, 4'd5, 4'd2, 1, 0, 4'd5, 1, 0, 0);
    idle(1);
    chk("lu.A.total", 32'(if_a.stall_cnt), 32'd2);
    chk("lu.A.state", 32'(if_a.dbg_state), 32'(HZ_RUN));
    idle(1);
    chk("lu.B.total", 32'(if_b.stall_cnt), 32'd3);
    chk("lu.C.total", 32'(if_c.stall_cnt), 32'd1);

    // Load to r0 read through rt.
    cyc(0, OP_ALU, 4'd1, 4'd0, 0, 1, 4'd0, 1, 0, 0);
    chk("zero.A.total", 32'(if_a.stall_cnt), 32'd2);
    chk("zero.B.state", 32'(if_b.dbg_state), 32'(HZ_LU_STALL));
    idle(3);

    // Taken branch squashes a coincident HLT and load-use in ID.
    cyc(0, HLT, 4'd5, 4'd2, 1, 0, 4'd5, 1, 1, 0);
    chk("br.A.state", 32'(if_a.dbg_state), 32'(HZ_RUN));
    chk("br.A.total", 32'(if_a.stall_cnt), 32'd2);

    // HLT at cycle N: B halts at N+1, C at N+2, A at N+3.
    cyc(0, HLT, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt.B.n1", 32'(if_b.halted), 32'd1);
    chk("hlt.A.n1", 32'(if_a.halted), 32'd0);
    idle(1);
    chk("hlt.C.n2", 32'(if_c.halted), 32'd1);
    chk("hlt.A.n2", 32'(if_a.halted), 32'd0);
    idle(1);
    chk("hlt.A.n3", 32'(if_a.halted), 32'd1);
    for (int i = 0; i < 20; i++)
      cyc(0, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0, 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("hlt.A.state", 32'(if_a.dbg_state), 32'(HZ_HALTED));
    chk("sat.C", 32'(if_c.stall_cnt), 32'd15);

    // mem_busy for 4 cycles inside the load-use stall.
    cyc(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, OP_ALU, 4'd5, 4'd2, 1, 0, 4'd5, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, OP_ALU, 4'd5, 4'd2, 1, 0, 4'd5, 1, 0, 1);
    chk("busy.B.state", 32'(if_b.dbg_state), 32'(HZ_LU_STALL));
    chk("busy.B.cnt", 32'(if_b.dbg_cnt), 32'd2);
    idle(2);
    chk("busy.B.total", 32'(if_b.stall_cnt), 32'd3);
    chk("busy.B.end", 32'(if_b.dbg_state), 32'(HZ_RUN));
    chk("busy.A.total", 32'(if_a.stall_cnt), 32'd2);

    // Reset while A is draining with cnt=2.
    cyc(0, HLT, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drn.A.state", 32'(if_a.dbg_state), 32'(HZ_HALT_DRAIN));
    chk("drn.A.cnt", 32'(if_a.dbg_cnt), 32'd2);
    cyc(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("drn.A.rst_state", 32'(if_a.dbg_state), 32'(HZ_RUN));
    chk("drn.A.rst_total", 32'(if_a.stall_cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 59) == 0),
          ($urandom_range(0, 79) == 0) ? HLT : 4'($urandom_range(0, 14)),
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
